frac_lutk_cfg: RTL and testbench
================================

Name: frac_lutk_cfg

Overview:
- Parametrised K-input fractured LUT with its own configuration shift chain, a configuration-sequencing FSM and a selectable output register.
- Successor to the fixed frac_lut4 primitive: generalises the input count and adds these behaviours:
  - serial config load with a bit-count check;
  - outputs held at 0 until the block is configured;
  - optional registered outputs.
- Sits in the CLB logic element, fed by the routing muxes; the config chain daisy-chains to the neighbouring LE.

Parameters:
- K, 4, LUT input count; legal range 3..6.
- LUT_BITS, 2**K, truth-table size; derived, never overridden.
- CFG_W, LUT_BITS+2 (+1 when parity is compiled in), config chain length; derived.

Ports:
- clk  in  1  single clock for the config chain and the output register.
- reset  in  1  synchronous, active-high reset.
- cfg_en  in  1  shift enable for the config chain.
- cfg_in  in  1  serial config data in.
- cfg_out  out  1  serial config data out; equals chain[CFG_W-1].
- cfg_done  out  1  high when the block is configured and active.
- cfg_err  out  1  sticky error: last load had the wrong bit count (or bad parity).
- in  in  K  LUT inputs; in[0] is the index LSB.
- frac_out  out  2  two (K-1)-input LUT outputs.
- lutk_out  out  1  K-input LUT output.

Behaviour:
- Chain layout:
  - chain[LUT_BITS-1:0] holds the truth table mem;
  - chain[LUT_BITS] is mode;
  - chain[LUT_BITS+1] is ffsel;
  - chain[LUT_BITS+2] is parity (only when parity is compiled in).
- Shift: when cfg_en=1 on a clk edge, chain <= {chain[CFG_W-2:0], cfg_in}. The first bit shifted in therefore ends at chain[CFG_W-1].
- Reset values: chain=0, state=UNCONF, cnt=0, cfg_done=0, cfg_err=0, output regs=0; all outputs 0.
- FSM states: UNCONF, SHIFT, ACTIVE.
  - UNCONF -> SHIFT when cfg_en=1. cnt <= 1, because this edge shifts the first bit.
  - SHIFT stays in SHIFT while cfg_en=1; cnt increments and saturates at CFG_W+1.
  - SHIFT exit when cfg_en=0:
    - cnt==CFG_W (and parity OK): go to ACTIVE, cfg_done <= 1, cfg_err <= 0.
    - otherwise: go to UNCONF, cfg_err <= 1.
  - ACTIVE -> SHIFT when cfg_en=1; cfg_done <= 0 and cnt <= 1 on that edge.
- Output gating: frac_out and lutk_out are forced to 0 whenever state != ACTIVE. cfg_done is registered; its first high cycle coincides with ACTIVE.
- LUT evaluation:
  - lo = in[K-2:0];
  - frac_out[0] = mem[{1'b0, lo}];
  - frac_out[1] = mem[{1'b1, lo}];
  - sel = in[K-1] | mode;
  - lutk_out = sel ? frac_out[1] : frac_out[0].
  - So when mode=1, lutk_out == frac_out[1].
- Output timing:
  - ffsel=0: outputs are combinational from in and the chain (zero latency).
  - ffsel=1: outputs come from registers that capture the gated LUT values every clk (1-cycle latency). The registers clear on reset and load 0 while not ACTIVE.
- Boundary cases:
  - reset asserted mid-shift: aborts the load; chain and state are cleared on that edge.
  - cfg_en=1 and reset=1 together: reset wins.
  - Over-shift (more than CFG_W bits): cnt saturates at CFG_W+1, so the exit goes to UNCONF with cfg_err set.
  - cfg_out is valid at all times, including during reset, where it reads 0.

Optional Feature:
- Macro: FRAC_LUTK_CFG_PARITY_EN.
- Defined:
  - CFG_W gains 1 bit;
  - the SHIFT exit additionally requires XOR of all CFG_W chain bits == 0 (even parity);
  - a parity mismatch goes to UNCONF and sets cfg_err.
- Undefined: there is no parity bit and only the bit count is checked.

Decomposition:
- Package frac_lutk_pkg holds:
  - the state enum (UNCONF=2'd0, SHIFT=2'd1, ACTIVE=2'd2);
  - the chain bit-index constants as functions of K;
  - the counter-width function clog2(CFG_W+2).
- Natural sub-module: frac_lutk_cfg_chain, containing the shift register, counter, FSM and parity check. The top level holds the LUT mux and output register.

Test Plan (K=4; CFG_W=18, or 19 with parity):
- AND4 load:
  - stimulus: shift 18 bits giving mem=16'h8000, mode=0, ffsel=0;
  - required: cfg_done=1 on the cycle after cfg_en drops; lutk_out=1 only for in=4'b1111; frac_out[1]=1 only for in[2:0]=3'b111.
- Short load:
  - stimulus: shift 17 bits, then drop cfg_en;
  - required: cfg_err=1, cfg_done=0, all outputs 0 for every in.
- Fracture:
  - stimulus: mem=16'hF0A5, mode=1;
  - required: frac_out[0] follows 8'hA5 and frac_out[1] follows 8'hF0, indexed by in[2:0]; lutk_out==frac_out[1] regardless of in[3].
- Registered output:
  - stimulus: ffsel=1, mem=16'h8000; drive in=4'hF at cycle t;
  - required: lutk_out=1 at t+1, and back to 0 one cycle after in changes.
- Reset mid-shift:
  - stimulus: assert reset after 9 shifts;
  - required: next cycle cfg_out=0, cfg_done=0, cfg_err=0; a full 18-bit reload then reaches ACTIVE.
- Parity (macro defined):
  - stimulus: 19-bit load with a wrong parity bit;
  - required: cfg_err=1, state stays UNCONF; the correct parity bit gives cfg_done=1.

Source files
------------

// File: rtl/frac_lutk_pkg.sv
// Shared types and layout helpers for the K-input fractured LUT.
// Optional parity bit on the config chain: FRAC_LUTK_CFG_PARITY_EN.
package frac_lutk_pkg;

  typedef enum logic [1:0] {
    UNCONF = 2'd0,
    SHIFT  = 2'd1,
    ACTIVE = 2'd2
  } cfg_state_e;

`ifdef FRAC_LUTK_CFG_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Truth-table size for a K-input LUT.
  function automatic int lut_bits_of(input int k);
    return 1 << k;
  endfunction

  // Chain bit positions: mem occupies [LUT_BITS-1:0], control bits sit above it.
  function automatic int mode_idx_of(input int k);
    return lut_bits_of(k);
  endfunction

  function automatic int ffsel_idx_of(input int k);
    return lut_bits_of(k) + 1;
  endfunction

  function automatic int parity_idx_of(input int k);
    return lut_bits_of(k) + 2;
  endfunction

  // Total config chain length.
  function automatic int cfg_w_of(input int k);
    return lut_bits_of(k) + 2 + PARITY_BITS;
  endfunction

  // Bit counter must reach CFG_W+1 (the over-shift saturation value).
  function automatic int cnt_w_of(input int k);
    return $clog2(cfg_w_of(k) + 2);
  endfunction

endpackage

// File: rtl/frac_lutk_cfg_chain.sv
// Config shift chain, bit counter and load-sequencing FSM for frac_lutk_cfg.
// With FRAC_LUTK_CFG_PARITY_EN the chain carries an extra even-parity bit
// that is verified when a load completes.
module frac_lutk_cfg_chain
  import frac_lutk_pkg::*;
#(
  parameter int K = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_en,
  input  logic                  cfg_in,
  output logic                  cfg_out,
  output logic                  cfg_done,
  output logic                  cfg_err,
  output logic                  active,
  output logic [(1<<K)-1:0]     mem,
  output logic                  mode,
  output logic                  ffsel
);

  localparam int LUT_BITS  = lut_bits_of(K);
  localparam int CFG_W     = cfg_w_of(K);
  localparam int CNT_W     = cnt_w_of(K);
  localparam int MODE_IDX  = mode_idx_of(K);
  localparam int FFSEL_IDX = ffsel_idx_of(K);

  logic [CFG_W-1:0] chain_reg;
  cfg_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;
  logic             load_ok;

  // Serial shift: first bit in ends up at the top of the chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain_reg <= '0;
    end else if (cfg_en) begin
      chain_reg <= {chain_reg[CFG_W-2:0], cfg_in};
    end
  end

  // A load is accepted only with the exact bit count (and even parity when compiled in).
`ifdef FRAC_LUTK_CFG_PARITY_EN
  assign load_ok = (cnt_reg == CNT_W'(CFG_W)) && ((^chain_reg) == 1'b0);
`else
  assign load_ok = (cnt_reg == CNT_W'(CFG_W));
`endif

  // State, counter and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= UNCONF;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  // Next-state logic; the edge that enters SHIFT already shifts the first bit.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    done_next  = done_reg;
    err_next   = err_reg;
    case (state_reg)
      UNCONF: begin
        if (cfg_en) begin
          state_next = SHIFT;
          cnt_next   = CNT_W'(1);
        end
      end
      SHIFT: begin
        if (cfg_en) begin
          if (cnt_reg != CNT_W'(CFG_W + 1)) begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end else if (load_ok) begin
          state_next = ACTIVE;
          done_next  = 1'b1;
          err_next   = 1'b0;
        end else begin
          state_next = UNCONF;
          err_next   = 1'b1;
        end
      end
      ACTIVE: begin
        if (cfg_en) begin
          state_next = SHIFT;
          done_next  = 1'b0;
          cnt_next   = CNT_W'(1);
        end
      end
      default: begin
        state_next = UNCONF;
        cnt_next   = '0;
        done_next  = 1'b0;
      end
    endcase
  end

  // Decoded outputs toward the LUT datapath and the neighbouring LE.
  always_comb begin
    active = 1'b0;
    if (state_reg == ACTIVE) begin
      active = 1'b1;
    end
  end

  // Held low during reset so the daisy chain never forwards stale config.
  assign cfg_out  = chain_reg[CFG_W-1] & ~reset;
  assign cfg_done = done_reg;
  assign cfg_err  = err_reg;
  assign mem      = chain_reg[LUT_BITS-1:0];
  assign mode     = chain_reg[MODE_IDX];
  assign ffsel    = chain_reg[FFSEL_IDX];

endmodule

// File: rtl/frac_lutk_cfg.sv
// K-input fractured LUT (K in 3..6) with serial config chain and optional
// output register. Build option FRAC_LUTK_CFG_PARITY_EN adds a parity bit
// to the config chain (handled inside frac_lutk_cfg_chain).
module frac_lutk_cfg
  import frac_lutk_pkg::*;
#(
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cfg_en,
  input  logic         cfg_in,
  output logic         cfg_out,
  output logic         cfg_done,
  output logic         cfg_err,
  input  logic [K-1:0] in,
  output logic [1:0]   frac_out,
  output logic         lutk_out
);

  localparam int LUT_BITS = lut_bits_of(K);

  logic [LUT_BITS-1:0] mem;
  logic                mode;
  logic                ffsel;
  logic                active;
  logic [K-2:0]        lo;
  logic [1:0]          frac_comb;
  logic [1:0]          frac_gated;
  logic                lutk_gated;
  logic [1:0]          frac_reg;
  logic                lutk_reg;

  frac_lutk_cfg_chain #(.K(K)) u_chain (
    .clk      (clk),
    .reset    (reset),
    .cfg_en   (cfg_en),
    .cfg_in   (cfg_in),
    .cfg_out  (cfg_out),
    .cfg_done (cfg_done),
    .cfg_err  (cfg_err),
    .active   (active),
    .mem      (mem),
    .mode     (mode),
    .ffsel    (ffsel)
  );

  assign lo = in[K-2:0];

  // Each half of the table is an independent (K-1)-input LUT.
  for (genvar gi = 0; gi < 2; gi++) begin : g_frac
    assign frac_comb[gi] = mem[{1'(gi), lo}];
  end

  // Gate the LUT off until the block holds a verified configuration.
  always_comb begin
    frac_gated = 2'b00;
    lutk_gated = 1'b0;
    if (active) begin
      frac_gated = frac_comb;
      lutk_gated = (in[K-1] | mode) ? frac_comb[1] : frac_comb[0];
    end
  end

  // Output register; loads 0 whenever the block is not active.
  always_ff @(posedge clk) begin
    if (reset) begin
      frac_reg <= 2'b00;
      lutk_reg <= 1'b0;
    end else begin
      frac_reg <= frac_gated;
      lutk_reg <= lutk_gated;
    end
  end

  // ffsel picks registered (1-cycle) or combinational (zero-latency) outputs.
  always_comb begin
    frac_out = frac_gated;
    lutk_out = lutk_gated;
    if (ffsel) begin
      frac_out = frac_reg;
      lutk_out = lutk_reg;
    end
  end

endmodule

// File: tb/tb_frac_lutk_cfg.sv
// Directed testbench for frac_lutk_cfg with K=4.
module tb_frac_lutk_cfg;

  localparam int K = 4;
`ifdef FRAC_LUTK_CFG_PARITY_EN
  localparam int CFG_W = 19;
`else
  localparam int CFG_W = 18;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_en = 1'b0;
  logic       cfg_in = 1'b0;
  logic [3:0] in_s = 4'h0;
  logic       cfg_out;
  logic       cfg_done;
  logic       cfg_err;
  logic [1:0] frac_out;
  logic       lutk_out;

  int total = 0;
  int bad = 0;

  frac_lutk_cfg #(.K(K)) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_en   (cfg_en),
    .cfg_in   (cfg_in),
    .cfg_out  (cfg_out),
    .cfg_done (cfg_done),
    .cfg_err  (cfg_err),
    .in       (in_s),
    .frac_out (frac_out),
    .lutk_out (lutk_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] mem;
    logic        mode;
    logic [3:0]  in;
    logic [1:0]  frac;
    logic        lutk;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, exp);
    end
  endtask

  // Shift nbits of the config word (first bit lands at chain[CFG_W-1]), then drop cfg_en
  // and wait one edge so the load has been judged.
  task automatic load_cfg(input logic [15:0] mem, input logic mode, input logic ffsel,
                          input int nbits, input logic bad_par);
    logic [18:0] w;
    w = '0;
    w[15:0] = mem;
    w[16] = mode;
    w[17] = ffsel;
`ifdef FRAC_LUTK_CFG_PARITY_EN
    w[18] = (^w[17:0]) ^ bad_par;
`else
    if (bad_par) $display("note: parity not compiled in, bad_par ignored");
`endif
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      cfg_en = 1'b1;
      cfg_in = (i < CFG_W) ? w[CFG_W-1-i] : 1'b0;
    end
    @(negedge clk);
    cfg_en = 1'b0;
    cfg_in = 1'b0;
    @(negedge clk);
    $display("load mem=%h mode=%0b ffsel=%0b bits=%0d -> done=%0b err=%0b",
             mem, mode, ffsel, nbits, cfg_done, cfg_err);
  endtask

  initial begin
    int nz;
    logic [15:0] cur_mem;
    logic        cur_mode;
    logic        have_cfg;

    vecs[0]  = '{16'h8000, 1'b0, 4'hF, 2'b10, 1'b1};
    vecs[1]  = '{16'h8000, 1'b0, 4'h7, 2'b10, 1'b0};
    vecs[2]  = '{16'h8000, 1'b0, 4'hE, 2'b00, 1'b0};
    vecs[3]  = '{16'h8000, 1'b0, 4'h0, 2'b00, 1'b0};
    vecs[4]  = '{16'h8000, 1'b0, 4'h8, 2'b00, 1'b0};
    vecs[5]  = '{16'hF0A5, 1'b1, 4'h0, 2'b01, 1'b0};
    vecs[6]  = '{16'hF0A5, 1'b1, 4'h5, 2'b11, 1'b1};
    vecs[7]  = '{16'hF0A5, 1'b1, 4'hD, 2'b11, 1'b1};
    vecs[8]  = '{16'hF0A5, 1'b1, 4'h4, 2'b10, 1'b1};
    vecs[9]  = '{16'hF0A5, 1'b1, 4'h1, 2'b00, 1'b0};
    vecs[10] = '{16'hF0A5, 1'b1, 4'hA, 2'b01, 1'b0};
    vecs[11] = '{16'hF0A5, 1'b1, 4'h3, 2'b00, 1'b0};
    vecs[12] = '{16'hF0A5, 1'b1, 4'h7, 2'b11, 1'b1};
    vecs[13] = '{16'hF0A5, 1'b0, 4'h2, 2'b01, 1'b1};
    vecs[14] = '{16'hF0A5, 1'b0, 4'hA, 2'b01, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_cfg_out", 32'(cfg_out), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("reset_done", 32'(cfg_done), 32'd0);
    check("reset_err", 32'(cfg_err), 32'd0);
    check("reset_frac", 32'(frac_out), 32'd0);
    check("reset_lutk", 32'(lutk_out), 32'd0);

    // Short load: one bit too few
    load_cfg(16'hFFFF, 1'b0, 1'b0, CFG_W - 1, 1'b0);
    check("short_err", 32'(cfg_err), 32'd1);
    check("short_done", 32'(cfg_done), 32'd0);
    nz = 0;
    for (int i = 0; i < 16; i++) begin
      in_s = 4'(i);
      #1;
      if (frac_out != 2'b00 || lutk_out != 1'b0) nz++;
    end
    check("short_outputs_nonzero", 32'(nz), 32'd0);

    // Over-shift: one bit too many
    load_cfg(16'hFFFF, 1'b0, 1'b0, CFG_W + 1, 1'b0);
    check("over_err", 32'(cfg_err), 32'd1);
    check("over_done", 32'(cfg_done), 32'd0);
    check("over_lutk", 32'(lutk_out), 32'd0);

    // Table-driven combinational vectors
    have_cfg = 1'b0;
    cur_mem = '0;
    cur_mode = 1'b0;
    for (int v = 0; v < 15; v++) begin
      if (!have_cfg || vecs[v].mem != cur_mem || vecs[v].mode != cur_mode) begin
        load_cfg(vecs[v].mem, vecs[v].mode, 1'b0, CFG_W, 1'b0);
        check("load_done", 32'(cfg_done), 32'd1);
        check("load_err", 32'(cfg_err), 32'd0);
        cur_mem = vecs[v].mem;
        cur_mode = vecs[v].mode;
        have_cfg = 1'b1;
      end
      @(negedge clk);
      in_s = vecs[v].in;
      #1;
      $display("vec %0d mem=%h mode=%0b in=%h frac=%b lutk=%b", v, vecs[v].mem,
               vecs[v].mode, vecs[v].in, frac_out, lutk_out);
      check($sformatf("vec%0d_frac", v), 32'(frac_out), 32'(vecs[v].frac));
      check($sformatf("vec%0d_lutk", v), 32'(lutk_out), 32'(vecs[v].lutk));
    end

    // Registered output, AND4
    load_cfg(16'h8000, 1'b0, 1'b1, CFG_W, 1'b0);
    check("ff_done", 32'(cfg_done), 32'd1);
    in_s = 4'h0;
    @(negedge clk);
    check("ff_idle", 32'(lutk_out), 32'd0);
    in_s = 4'hF;
    #1;
    check("ff_latency", 32'(lutk_out), 32'd0);
    @(negedge clk);
    check("ff_lutk_t1", 32'(lutk_out), 32'd1);
    check("ff_frac_t1", 32'(frac_out), 32'd2);
    in_s = 4'h0;
    #1;
    check("ff_hold", 32'(lutk_out), 32'd1);
    @(negedge clk);
    check("ff_fall", 32'(lutk_out), 32'd0);
    $display("registered sequence complete");

    // Reset in the middle of a shift
    load_cfg(16'hFFFF, 1'b0, 1'b0, CFG_W, 1'b0);
    check("rst_pre_done", 32'(cfg_done), 32'd1);
    in_s = 4'h0;
    #1;
    check("rst_pre_lutk", 32'(lutk_out), 32'd1);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      cfg_en = 1'b1;
      cfg_in = 1'b1;
    end
    @(negedge clk);
    check("rst_mid_cfg_out", 32'(cfg_out), 32'd1);
    check("rst_mid_done", 32'(cfg_done), 32'd0);
    reset = 1'b1;
    #1;
    check("rst_during_cfg_out", 32'(cfg_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cfg_en = 1'b0;
    cfg_in = 1'b0;
    #1;
    check("rst_post_cfg_out", 32'(cfg_out), 32'd0);
    check("rst_post_done", 32'(cfg_done), 32'd0);
    check("rst_post_err", 32'(cfg_err), 32'd0);
    check("rst_post_lutk", 32'(lutk_out), 32'd0);
    load_cfg(16'h8000, 1'b0, 1'b0, CFG_W, 1'b0);
    check("rst_reload_done", 32'(cfg_done), 32'd1);
    in_s = 4'hF;
    #1;
    check("rst_reload_lutk", 32'(lutk_out), 32'd1);

`ifdef FRAC_LUTK_CFG_PARITY_EN
    // Parity bit checking
    load_cfg(16'h8000, 1'b0, 1'b0, CFG_W, 1'b1);
    check("par_bad_err", 32'(cfg_err), 32'd1);
    check("par_bad_done", 32'(cfg_done), 32'd0);
    in_s = 4'hF;
    #1;
    check("par_bad_lutk", 32'(lutk_out), 32'd0);
    load_cfg(16'h8000, 1'b0, 1'b0, CFG_W, 1'b0);
    check("par_good_done", 32'(cfg_done), 32'd1);
    check("par_good_err", 32'(cfg_err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
